// File: rtl/sequenciador_pkg.sv
// sequenciador_pkg: shared state encoding, BCD time constants and BCD/binary helpers.
package sequenciador_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, COOK, PAUSE, DONE} state_t;
  localparam logic [15:0] TEMPO_ZERO = 16'h0000;
  localparam logic [15:0] TEMPO_MAX = 16'h9959;
  localparam logic [15:0] QUICK_ADD = 16'h0030;
  function automatic logic [7:0] to_bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction
endpackage

// File: rtl/registrador_tempo_bcd.sv
// registrador_tempo_bcd: MM:SS BCD tempo register with shift, decrement, +30 s and clear commands.
module registrador_tempo_bcd
  import sequenciador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_in,
  input  logic [3:0]  d,
  input  logic        decrement,
  input  logic        add30,
  input  logic        zero,
  output logic [15:0] tempo,
  output logic        is_zero
);
  logic [15:0] dec, add, tempo_d;
  logic [7:0] sec, min;
  always_comb begin
    dec = tempo;
    if (tempo[3:0] != 4'd0) dec[3:0] = tempo[3:0] - 4'd1;
    else if (tempo[7:4] != 4'd0) dec[7:0] = {tempo[7:4] - 4'd1, 4'd9};
    else if (tempo[15:8] != 8'd0)
      dec = {(tempo[11:8] != 4'd0) ? {tempo[15:12], tempo[11:8] - 4'd1} : {tempo[15:12] - 4'd1, 4'd9}, 8'h59};
    // entered seconds may reach 99, so the +30 can carry into minutes twice
    sec = to_bin(tempo[7:0]) + to_bin(QUICK_ADD[7:0]);
    min = to_bin(tempo[15:8]) + to_bin(QUICK_ADD[15:8]);
    if (sec >= 8'd60) begin
      sec = sec - 8'd60;
      min = min + 8'd1;
    end
    if (sec >= 8'd60) begin
      sec = sec - 8'd60;
      min = min + 8'd1;
    end
    add = (min > 8'd99) ? TEMPO_MAX : {to_bcd(min), to_bcd(sec)};
    tempo_d = zero ? TEMPO_ZERO : add30 ? add : decrement ? dec : shift_in ? {tempo[11:0], d} : tempo;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) tempo <= TEMPO_ZERO;
    else tempo <= tempo_d;
  assign is_zero = (tempo == TEMPO_ZERO);
endmodule

// File: rtl/sequenciador_tempo.sv
// sequenciador_tempo: microwave cooking-time entry, countdown and magnetron control FSM.
// Optional QUICK_START_30S_EN: start in IDLE loads 0030, start while cooking adds 30 s.
module sequenciador_tempo
  import sequenciador_pkg::*;
#(
  parameter int DONE_HOLD_S = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Hz_100_clock,
  input  logic        clear,
  input  logic [3:0]  D,
  input  logic        loadn,
  input  logic        pgt_1Hz,
  input  logic        startn,
  input  logic        stopn,
  input  logic        door_closed,
  output logic        enablen,
  output logic        magnetron_on,
  output logic [15:0] tempo,
  output logic        done
);
`ifdef QUICK_START_30S_EN
  localparam bit QUICK_EN = 1'b1;
`else
  localparam bit QUICK_EN = 1'b0;
`endif
  logic [SYNC_STAGES-1:0][8:0] sync;
  logic [8:0] s;
  logic [3:0] edge_q, cnt, cnt_d;
  logic key, tick, start, stop, door_s, key_nz;
  logic shift_in, decrement, add30, zero, is_zero;
  state_t state, state_d;
  assign s = sync[SYNC_STAGES-1];
  assign door_s = s[0];
  assign key = edge_q[3] & ~s[4] & (s[8:5] <= 4'd9);
  assign tick = ~edge_q[2] & s[3];
  assign start = edge_q[1] & ~s[2];
  assign stop = edge_q[0] & ~s[1];
  assign key_nz = |{tempo[11:0], s[8:5]};
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    shift_in = 1'b0;
    decrement = 1'b0;
    add30 = 1'b0;
    zero = 1'b0;
    case (state)
      IDLE:
        if (QUICK_EN && start && !stop && door_s && is_zero) begin
          add30 = 1'b1;
          state_d = COOK;
        end else if (key && !start && !stop) begin
          shift_in = 1'b1;
          state_d = key_nz ? ENTRY : IDLE;
        end
      ENTRY:
        if (stop) begin
          zero = 1'b1;
          state_d = IDLE;
        end else if (start) state_d = (door_s && !is_zero) ? COOK : ENTRY;
        else shift_in = key;
      COOK:
        if (stop || !door_s) state_d = PAUSE;
        else if (start) add30 = QUICK_EN;
        else if (tick) begin
          decrement = 1'b1;
          // only 0001 decrements to 0000
          if (tempo == 16'h0001) begin
            state_d = DONE;
            cnt_d = '0;
          end
        end
      PAUSE:
        if (stop) begin
          zero = 1'b1;
          state_d = IDLE;
        end else if (start && door_s) state_d = COOK;
      DONE:
        if (stop) state_d = IDLE;
        else if (tick) begin
          cnt_d = cnt + 4'd1;
          state_d = (cnt == 4'(DONE_HOLD_S - 1)) ? IDLE : DONE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Hz_100_clock or posedge clear)
    if (clear) begin
      sync <= '0;
      edge_q <= '0;
      state <= IDLE;
      cnt <= '0;
      enablen <= 1'b0;
      magnetron_on <= 1'b0;
      done <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {D, loadn, pgt_1Hz, startn, stopn, door_closed}};
      edge_q <= s[4:1];
      state <= state_d;
      cnt <= cnt_d;
      enablen <= (state_d != IDLE) && (state_d != ENTRY);
      magnetron_on <= (state_d == COOK);
      done <= (state_d == DONE);
    end
  registrador_tempo_bcd u_reg (
    .clk(Hz_100_clock),
    .rst(clear),
    .shift_in(shift_in),
    .d(s[8:5]),
    .decrement(decrement),
    .add30(add30),
    .zero(zero),
    .tempo(tempo),
    .is_zero(is_zero)
  );
endmodule

// File: tb/tb_sequenciador_tempo.sv
// tb_sequenciador_tempo: directed and random stimulus checked against a decimal-arithmetic reference model.
module tb_sequenciador_tempo;
  localparam int SYNC = 2, HOLD = 3;
`ifdef QUICK_START_30S_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif
  logic clk = 1'b0, clear, loadn, pgt, startn, stopn, door;
  logic [3:0] D;
  logic enablen, magnetron_on, done;
  logic [15:0] tempo;
  int n_cmp = 0, n_err = 0;
  typedef enum {M_IDLE, M_ENTRY, M_COOK, M_PAUSE, M_DONE} mstate_t;
  mstate_t ms = M_IDLE;
  int mv = 0, mc = 0;
  bit md = 1'b1;
  always #5 clk = ~clk;
  sequenciador_tempo #(.DONE_HOLD_S(HOLD), .SYNC_STAGES(SYNC)) dut (
    .Hz_100_clock(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt),
    .startn(startn), .stopn(stopn), .door_closed(door),
    .enablen(enablen), .magnetron_on(magnetron_on), .tempo(tempo), .done(done)
  );
  function automatic logic [15:0] bcd(input int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction
  function automatic int plus30(input int v);
    int t = (v / 100) * 60 + v % 100 + 30;
    if (t > 99 * 60 + 59) return 9959;
    return (t / 60) * 100 + t % 60;
  endfunction
  function automatic int minus1(input int v);
    if (v % 100 > 0) return v - 1;
    if (v / 100 > 0) return (v / 100 - 1) * 100 + 59;
    return 0;
  endfunction
  task automatic model(input bit st, input bit sp, input bit tk, input bit ky, input int d);
    case (ms)
      M_IDLE:
        if (QUICK && st && !sp && md && mv == 0) begin mv = plus30(mv); ms = M_COOK; end
        else if (ky && !st && !sp && d <= 9) begin
          mv = (mv * 10 + d) % 10000;
          if (mv != 0) ms = M_ENTRY;
        end
      M_ENTRY:
        if (sp) begin mv = 0; ms = M_IDLE; end
        else if (st) begin if (md && mv != 0) ms = M_COOK; end
        else if (ky && d <= 9) mv = (mv * 10 + d) % 10000;
      M_COOK:
        if (sp || !md) ms = M_PAUSE;
        else if (st) begin if (QUICK) mv = plus30(mv); end
        else if (tk) begin
          mv = minus1(mv);
          if (mv == 0) begin ms = M_DONE; mc = 0; end
        end
      M_PAUSE:
        if (sp) begin mv = 0; ms = M_IDLE; end
        else if (st && md) ms = M_COOK;
      M_DONE:
        if (sp) ms = M_IDLE;
        else if (tk) begin mc++; if (mc == HOLD) ms = M_IDLE; end
    endcase
  endtask
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".tempo"}, tempo, bcd(mv));
    check({tag, ".enablen"}, {15'b0, enablen}, 16'(ms inside {M_COOK, M_PAUSE, M_DONE}));
    check({tag, ".magnetron"}, {15'b0, magnetron_on}, 16'(ms == M_COOK));
    check({tag, ".done"}, {15'b0, done}, 16'(ms == M_DONE));
  endtask
  task automatic act(input string tag, input bit st, input bit sp, input bit tk, input bit ky, input int d, input bit dl);
    @(negedge clk);
    door = dl;
    md = dl;
    if (ky) begin D = 4'(d); loadn = 1'b0; end
    startn = ~st;
    stopn = ~sp;
    pgt = tk;
    model(st, sp, tk, ky, d);
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    loadn = 1'b1; startn = 1'b1; stopn = 1'b1; pgt = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic key(input string tag, input int d); act(tag, 0, 0, 0, 1, d, md); endtask
  task automatic start(input string tag); act(tag, 1, 0, 0, 0, 0, md); endtask
  task automatic stop(input string tag); act(tag, 0, 1, 0, 0, 0, md); endtask
  task automatic tick(input string tag); act(tag, 0, 0, 1, 0, 0, md); endtask
  initial begin
    clear = 1'b1; loadn = 1'b1; startn = 1'b1; stopn = 1'b1; pgt = 1'b0; door = 1'b1; D = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    clear = 1'b0;
    repeat (5) @(posedge clk);
    key("k1", 1); key("k2", 2); key("k3", 3); key("k1230", 0);
    key("k2305", 5);
    stop("entry_stop");
    key("a0", 0); key("a0", 0); key("a0", 0); key("a0002", 2);
    @(negedge clk);
    startn = 1'b0;
    model(1, 0, 0, 0, 0);
    repeat (SYNC) @(posedge clk);
    #1 check("start_latency_early", {15'b0, magnetron_on}, 16'd0);
    @(posedge clk);
    #1 check("start_latency_edge", {15'b0, magnetron_on}, 16'd1);
    @(negedge clk);
    startn = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    check_all("cook_0002");
    tick("tick_0001"); tick("tick_done");
    tick("hold1"); tick("hold2"); tick("hold3_idle");
    key("b", 1); key("b", 0); key("b0100", 0); start("start_0100"); tick("tick_0059");
    stop("pause"); stop("idle");
    key("c", 9); key("c0090", 0); start("start_0090"); tick("tick_0089");
    stop("pause"); stop("idle");
    key("e", 1); key("e0010", 0); start("start_0010");
    act("door_open_tick", 0, 0, 1, 0, 0, 0);
    act("door_close", 0, 0, 0, 0, 0, 1);
    start("resume_0010");
    stop("pause_again"); stop("pause_stop_idle");
    key("f0005", 5);
    act("door_open_entry", 0, 0, 0, 0, 0, 0);
    start("start_door_open");
    act("door_close_entry", 0, 0, 0, 0, 0, 1);
    act("start_and_stop", 1, 1, 0, 0, 0, 1);
    key("g0009", 9); start("start_0009");
    #3 clear = 1'b1;
    ms = M_IDLE; mv = 0;
    #1 check_all("async_clear");
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(posedge clk);
`ifdef QUICK_START_30S_EN
    start("quick_0030");
    stop("pause"); stop("idle");
    key("h", 9); key("h", 9); key("h", 4); key("h9945", 5); start("start_9945");
    start("quick_sat_9959");
    stop("pause"); stop("idle");
`endif
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) key($sformatf("rnd%0d.key", i), int'($urandom_range(0, 15)));
      else if (r < 60) start($sformatf("rnd%0d.start", i));
      else if (r < 67) stop($sformatf("rnd%0d.stop", i));
      else if (r < 88) tick($sformatf("rnd%0d.tick", i));
      else act($sformatf("rnd%0d.door", i), 0, 0, 0, 0, 0, ~md);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
